// File: rtl/fetch_unit_q.sv
// Instruction fetch front end: sequential PC, memory read handshake, {pc,inst} FIFO with redirect flush.
// Optional macro FETCH_BR_STALL_EN: after enqueueing a control-transfer opcode, stall until br_done/redirect.
module fetch_unit_q #(
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_read,
  output logic [31:0]               mem_address,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_resp,
  input  logic                      deq,
  output logic                      inst_valid,
  output logic [31:0]               inst_out,
  output logic [31:0]               pc_out,
  output logic [$clog2(QDEPTH):0]   q_count,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  input  logic                      br_done
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

`ifdef FETCH_BR_STALL_EN
  typedef enum logic [1:0] {ISSUE, WAIT, DROP, BR_WAIT} state_t;
`else
  typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;
`endif

  state_t          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     addr_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     pc_mem_q   [QDEPTH];
  logic [31:0]     inst_mem_q [QDEPTH];

  logic [31:0]     redir_pc;
  logic            enq, deq_ok;

  assign redir_pc = {redirect_pc[31:2], 2'b00};
  // A response coinciding with a redirect belongs to the squashed path and is dropped.
  assign enq      = (state_q == WAIT) && mem_resp && !redirect;
  assign deq_ok   = deq && (cnt_q != '0) && !redirect;

`ifdef FETCH_BR_STALL_EN
  function automatic logic is_ctrl(input logic [31:0] w);
    return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
  endfunction
  logic unused_ok;
  assign unused_ok = ^redirect_pc[1:0];
`else
  logic unused_ok;
  assign unused_ok = ^{redirect_pc[1:0], br_done};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ISSUE: begin
          if (redirect) begin
            pc_q <= redir_pc;
          end else if (cnt_q < FULL) begin
            addr_q  <= pc_q;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp) begin
            state_q <= ISSUE;
            if (redirect) begin
              pc_q <= redir_pc;
            end else begin
              pc_q <= addr_q + 32'd4;
`ifdef FETCH_BR_STALL_EN
              if (is_ctrl(mem_rdata)) state_q <= BR_WAIT;
`endif
            end
          end else if (redirect) begin
            pc_q    <= redir_pc;
            state_q <= DROP;
          end
        end
        DROP: begin
          // Keep the stale request alive until memory answers, then restart.
          if (redirect) pc_q <= redir_pc;
          if (mem_resp) state_q <= ISSUE;
        end
`ifdef FETCH_BR_STALL_EN
        BR_WAIT: begin
          if (redirect) begin
            pc_q    <= redir_pc;
            state_q <= ISSUE;
          end else if (br_done) begin
            state_q <= ISSUE;
          end
        end
`endif
        default: state_q <= ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (enq)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (enq && !deq_ok)      cnt_q <= cnt_q + 1'b1;
      else if (!enq && deq_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]   <= addr_q;
      inst_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_read    = (state_q == WAIT) || (state_q == DROP);
  assign mem_address = addr_q;
  assign q_count     = cnt_q;
  assign inst_valid  = (cnt_q != '0);
  // Empty queue presents zeros rather than stale storage.
  assign inst_out    = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign pc_out      = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_fetch_unit_q.sv
// Bench for fetch_unit_q: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit_q;
  localparam int          QD  = 8;
  localparam logic [31:0] RPC = 32'h00000060;

  logic        clk = 0;
  logic        rst;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        deq;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [3:0]  q_count;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        br_done;

  fetch_unit_q #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .deq(deq), .inst_valid(inst_valid),
    .inst_out(inst_out), .pc_out(pc_out), .q_count(q_count), .redirect(redirect),
    .redirect_pc(redirect_pc), .br_done(br_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int lat_mode  = 0;   // <0: random 0..3 per request
  bit br_mode   = 0;
  bit hash_mode = 0;
  int mcnt = 0, mlat_r = 0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (br_mode && a == 32'h70) return 32'h00000063;
    if (hash_mode) return (a * 32'h9E3779B1) ^ 32'h00005A5B;
    return a;
  endfunction

  initial begin
    mem_resp  = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_read !== 1'b1) begin
        mcnt = 0; mem_resp = 0; mem_rdata = 32'hDEADBEEF;
      end else begin
        if (mcnt == 0) mlat_r = $urandom_range(0, 3);
        mem_resp  = (mcnt >= ((lat_mode < 0) ? mlat_r : lat_mode));
        mem_rdata = mem_resp ? memdata(mem_address) : 32'hDEADBEEF;
        mcnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_REQ = 1, M_DROP = 2, M_BRW = 3;
  bit          m_ok = 0;
  int          m_ph;
  logic [31:0] m_pc, m_addr;
  logic [31:0] qpc[$];
  logic [31:0] qin[$];

  task automatic model_step();
    logic [31:0] rp, d;
    bit e;
    if (rst === 1'b1) begin
      m_ok = 1; m_pc = RPC; m_ph = M_IDLE; m_addr = 0;
      qpc.delete(); qin.delete();
      return;
    end
    if (!m_ok) return;
    rp = {redirect_pc[31:2], 2'b00};
    e = 0; d = 0;
    case (m_ph)
      M_IDLE: if (redirect) m_pc = rp;
              else if (qpc.size() < QD) begin m_addr = m_pc; m_ph = M_REQ; end
      M_REQ: begin
        if (mem_resp) begin
          m_ph = M_IDLE;
          if (redirect) m_pc = rp;
          else begin
            e = 1; d = mem_rdata; m_pc = m_addr + 32'd4;
`ifdef FETCH_BR_STALL_EN
            if (d[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111}) m_ph = M_BRW;
`endif
          end
        end else if (redirect) begin
          m_pc = rp; m_ph = M_DROP;
        end
      end
      M_DROP: begin
        if (redirect) m_pc = rp;
        if (mem_resp) m_ph = M_IDLE;
      end
      default: if (redirect) begin m_pc = rp; m_ph = M_IDLE; end
               else if (br_done) m_ph = M_IDLE;
    endcase
    if (redirect) begin
      qpc.delete(); qin.delete();
    end else begin
      if (deq && qpc.size() > 0) begin void'(qpc.pop_front()); void'(qin.pop_front()); end
      if (e) begin qpc.push_back(m_addr); qin.push_back(d); end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  initial forever begin
    logic        e_rd, e_v;
    logic [31:0] e_a, e_i, e_p;
    int          e_c;
    @(negedge clk);
    cyc++;
    if (m_ok) begin
      e_rd = (m_ph == M_REQ) || (m_ph == M_DROP);
      e_a  = m_addr;
      e_c  = qpc.size();
      e_v  = (e_c > 0);
      e_i  = e_v ? qin[0] : 32'h0;
      e_p  = e_v ? qpc[0] : 32'h0;
      tests++;
      if (mem_read !== e_rd || mem_address !== e_a || inst_valid !== e_v ||
          inst_out !== e_i || pc_out !== e_p || int'(q_count) != e_c) begin
        fails++;
        $display("FAIL model cycle %0d: got rd=%b a=%h v=%b i=%h p=%h c=%0d expected rd=%b a=%h v=%b i=%h p=%h c=%0d",
                 cyc, mem_read, mem_address, inst_valid, inst_out, pc_out, q_count,
                 e_rd, e_a, e_v, e_i, e_p, e_c);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; deq = 0; redirect = 0; br_done = 0;
    @(negedge clk);
    chk("reset mem_read", {31'b0, mem_read}, 32'h0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset q_count", {28'b0, q_count}, 32'h0);
    chk("reset inst_out", inst_out, 32'h0);
    rst = 0;
  endtask

  task automatic wait_read(input logic v, input string nm);
    int n = 0;
    while (mem_read !== v && n < 60) begin @(negedge clk); n++; end
    chk(nm, {31'b0, mem_read}, {31'b0, v});
  endtask

  initial begin
    rst = 1; deq = 0; redirect = 0; redirect_pc = 0; br_done = 0;

    // Fill with 1-cycle memory, no deq
    lat_mode = 0;
    do_reset();
    step(1);
    chk("first req", {31'b0, mem_read}, 32'h1);
    chk("first addr", mem_address, 32'h60);
    step(2);
    chk("second addr", mem_address, 32'h64);
    step(20);
    chk("full q_count", {28'b0, q_count}, 32'd8);
    chk("full no read", {31'b0, mem_read}, 32'h0);
    chk("full head pc", pc_out, 32'h60);
    chk("full head inst", inst_out, 32'h60);

    // Drain 4 with memory stalled, then refill
    lat_mode = 1000;
    for (int k = 0; k < 4; k++) begin
      chk("deq pc seq", pc_out, 32'h60 + 32'(4 * k));
      deq = 1;
      @(negedge clk);
    end
    deq = 0;
    chk("drained q_count", {28'b0, q_count}, 32'd4);
    chk("drained head", pc_out, 32'h70);
    lat_mode = 0;
    step(12);
    chk("refill q_count", {28'b0, q_count}, 32'd8);

    // Redirect while waiting on a slow response
    lat_mode = 3;
    do_reset();
    step(1);
    redirect = 1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 0;
    chk("drop read held", {31'b0, mem_read}, 32'h1);
    chk("drop addr held", mem_address, 32'h60);
    wait_read(0, "drop release");
    wait_read(1, "post-drop req");
    chk("post-drop addr", mem_address, 32'h200);
    step(5);
    chk("post-drop count", {28'b0, q_count}, 32'd1);
    chk("post-drop head", pc_out, 32'h200);

    // Redirect coincident with response and deq
    lat_mode = 0;
    do_reset();
    step(6);
    wait_read(1, "pre-coincide req");
    redirect = 1; redirect_pc = 32'h303; deq = 1;
    @(negedge clk);
    redirect = 0; deq = 0;
    chk("coincide q_count", {28'b0, q_count}, 32'd0);
    wait_read(1, "coincide req");
    chk("coincide addr", mem_address, 32'h300);

    // PC wrap
    redirect = 1; redirect_pc = 32'hFFFFFFFC;
    @(negedge clk);
    redirect = 0;
    wait_read(1, "wrap req");
    chk("wrap addr0", mem_address, 32'hFFFFFFFC);
    wait_read(0, "wrap gap");
    wait_read(1, "wrap req2");
    chk("wrap addr1", mem_address, 32'h0);

    // Reset mid-request
    lat_mode = 3;
    step(2);
    wait_read(1, "pre-rst req");
    rst = 1;
    @(negedge clk);
    chk("rst mid read", {31'b0, mem_read}, 32'h0);
    chk("rst mid count", {28'b0, q_count}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("rst restart", mem_address, 32'h60);

`ifdef FETCH_BR_STALL_EN
    lat_mode = 0; br_mode = 1;
    do_reset();
    step(14);
    chk("br stall read", {31'b0, mem_read}, 32'h0);
    chk("br stall count", {28'b0, q_count}, 32'd5);
    br_done = 1;
    @(negedge clk);
    br_done = 0;
    wait_read(1, "br_done req");
    chk("br_done addr", mem_address, 32'h74);
    do_reset();
    step(14);
    chk("br stall2 read", {31'b0, mem_read}, 32'h0);
    redirect = 1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 0;
    wait_read(1, "br redir req");
    chk("br redir addr", mem_address, 32'h100);
    br_mode = 0;
`endif

    // Randomized traffic
    lat_mode = -1; hash_mode = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int dp;
      dp = (i / 500) % 3 == 0 ? 10 : ((i / 500) % 3 == 1 ? 50 : 90);
      deq         = ($urandom_range(0, 99) < dp);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = $urandom;
      br_done     = ($urandom_range(0, 99) < 20);
      rst         = ($urandom_range(0, 999) < 3);
      @(negedge clk);
    end
    rst = 0; deq = 0; redirect = 0; br_done = 0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
